stopwatch_ctrl: RTL and testbench

//  Command sequencer for the stopwatch datapath. Merges debounced button pulses and UART RX command bytes

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/bin2bcd99.sv | 20 ++
 rtl/stopwatch_ctrl.sv | 153 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, ASCII constants and command decoding for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {CMD_NONE, CMD_TOGGLE, CMD_CLEAR, CMD_REPORT} cmd_t;
  typedef enum logic {IDLE, SEND} rpt_state_t;

  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_DOT   = 8'h2E;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return CHAR_ZERO + {4'd0, d};
  endfunction

  // Lower-case letters are folded onto upper case only when allowed.
  function automatic cmd_t decode_cmd(input logic [7:0] b, input bit lower_ok);
    logic [7:0] c;
    c = (lower_ok && b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
    case (c)
      8'h53:   return CMD_TOGGLE;  // 'S'
      8'h52:   return CMD_CLEAR;   // 'R'
      8'h54,
      8'h4C:   return CMD_REPORT;  // 'T', 'L'
      default: return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 0..99 binary to two-digit BCD via compare/subtract.
module bin2bcd99 (
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_tens = 4'd0;
    o_ones = i_bin[3:0];
    for (int t = 1; t <= 9; t++) begin
      if (i_bin >= 7'(10 * t)) begin
        o_tens = 4'(t);
        o_ones = 4'(i_bin - 7'(10 * t));
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Merges button and UART commands into stopwatch strobes and streams the
// snapshotted time as ASCII "HH:MM:SS.cc" over a ready/valid TX port.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit TX_CRLF  = 1'b1,
  parameter bit LOWER_OK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [6:0] milliseconds,
  output logic       sw_start,
  output logic [1:0] sw_sel,
  output logic       sw_clear,
  output logic       running,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0] LAST_IDX = TX_CRLF ? 4'd12 : 4'd10;

  cmd_t       w_rx_cmd;
  logic       w_clear, w_toggle, w_report;
  rpt_state_t r_state, w_next_state;
  logic       w_start_rpt, w_last_hs, w_hs, w_drop;
  logic       r_sw_start, r_sw_clear, r_running, r_overrun, r_pending;
  logic [1:0] r_sw_sel;
  logic [3:0] r_idx;
  logic [5:0] r_snap_h, r_snap_m, r_snap_s;
  logic [6:0] r_snap_c;
  logic [3:0] w_h1, w_h0, w_m1, w_m0, w_s1, w_s0, w_c1, w_c0;
  logic [7:0] w_byte;

  // Clear beats toggle; report requests are independent of both.
  assign w_rx_cmd = rx_valid ? decode_cmd(rx_data, LOWER_OK) : CMD_NONE;
  assign w_clear  = (w_rx_cmd == CMD_CLEAR);
  assign w_toggle = (btn_start || w_rx_cmd == CMD_TOGGLE) && !w_clear;
  assign w_report = btn_lap || (w_rx_cmd == CMD_REPORT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_start <= 1'b0;
      r_sw_sel   <= 2'd3;
      r_sw_clear <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_sw_start <= w_toggle;
      r_sw_sel   <= w_toggle ? 2'd0 : 2'd3;
      r_sw_clear <= w_clear;
      if (w_clear)       r_running <= 1'b0;
      else if (w_toggle) r_running <= ~r_running;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start_rpt  = 1'b0;
    w_last_hs    = 1'b0;
    case (r_state)
      IDLE: if (w_report || r_pending) begin
        w_next_state = SEND;
        w_start_rpt  = 1'b1;
      end
      SEND: if (tx_ready && r_idx == LAST_IDX) begin
        w_next_state = IDLE;
        w_last_hs    = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_hs   = (r_state == SEND) && tx_ready;
  assign w_drop = (r_state == SEND) && w_report && r_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= 4'd0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_start_rpt) begin
        r_idx     <= 4'd0;
        r_pending <= r_pending && w_report;
      end else if (r_state == SEND) begin
        if (w_hs && !w_last_hs) r_idx <= r_idx + 4'd1;
        if (w_report)           r_pending <= 1'b1;
      end
      if (w_clear)     r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
    end
  end

  // NOTE: snapshot registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (w_start_rpt) begin
      r_snap_h <= hours;
      r_snap_m <= minutes;
      r_snap_s <= seconds;
      r_snap_c <= milliseconds;
    end
  end

  bin2bcd99 u_bcd_h (.i_bin({1'b0, r_snap_h}), .o_tens(w_h1), .o_ones(w_h0));
  bin2bcd99 u_bcd_m (.i_bin({1'b0, r_snap_m}), .o_tens(w_m1), .o_ones(w_m0));
  bin2bcd99 u_bcd_s (.i_bin({1'b0, r_snap_s}), .o_tens(w_s1), .o_ones(w_s0));
  bin2bcd99 u_bcd_c (.i_bin(r_snap_c),         .o_tens(w_c1), .o_ones(w_c0));

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = ascii_digit(w_h1);
      4'd1:    w_byte = ascii_digit(w_h0);
      4'd2:    w_byte = CHAR_COLON;
      4'd3:    w_byte = ascii_digit(w_m1);
      4'd4:    w_byte = ascii_digit(w_m0);
      4'd5:    w_byte = CHAR_COLON;
      4'd6:    w_byte = ascii_digit(w_s1);
      4'd7:    w_byte = ascii_digit(w_s0);
      4'd8:    w_byte = CHAR_DOT;
      4'd9:    w_byte = ascii_digit(w_c1);
      4'd10:   w_byte = ascii_digit(w_c0);
      4'd11:   w_byte = CHAR_CR;
      4'd12:   w_byte = CHAR_LF;
      default: w_byte = 8'h00;
    endcase
  end

  assign sw_start = r_sw_start;
  assign sw_sel   = r_sw_sel;
  assign sw_clear = r_sw_clear;
  assign running  = r_running;
  assign overrun  = r_overrun;
  assign tx_valid = (r_state == SEND);
  assign busy     = (r_state != IDLE);
  assign tx_data  = (r_state == SEND) ? w_byte : 8'h00;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected TX bytes are queued by the
// stimulus and popped by an independent monitor on every handshake.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_lap, rx_valid, tx_ready;
  logic [7:0] rx_data;
  logic [5:0] hours, minutes, seconds;
  logic [6:0] milliseconds;
  logic       sw_start, sw_clear, running, tx_valid, busy, overrun;
  logic [1:0] sw_sel;
  logic [7:0] tx_data;

  logic [7:0] exp_q[$];
  logic [7:0] t3[13];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TX_CRLF(1'b1), .LOWER_OK(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .rx_valid(rx_valid), .rx_data(rx_data), .hours(hours), .minutes(minutes),
    .seconds(seconds), .milliseconds(milliseconds), .sw_start(sw_start),
    .sw_sel(sw_sel), .sw_clear(sw_clear), .running(running), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    hours = 6'(h); minutes = 6'(m); seconds = 6'(s); milliseconds = 7'(c);
  endtask

  task automatic push_report(input int h, input int m, input int s, input int c);
    exp_q.push_back(8'(48 + h / 10)); exp_q.push_back(8'(48 + h % 10));
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'(48 + m / 10)); exp_q.push_back(8'(48 + m % 10));
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'(48 + s / 10)); exp_q.push_back(8'(48 + s % 10));
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'(48 + c / 10)); exp_q.push_back(8'(48 + c % 10));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step(1);
    end
    check("idle_timeout", busy, 0);
  endtask

  // Monitor: pop on handshake, compare held byte against queue head while stalled.
  always @(negedge clk) begin
    if (!reset && tx_valid) begin
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx: got %02h expected no byte at %0t", tx_data, $time);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end else if (exp_q.size() > 0) begin
        check("tx_hold", tx_data, exp_q[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; tx_ready = 1'b1;
    set_time(0, 0, 0, 0);
    #12;
    @(negedge clk) reset = 1'b0;
    step(1);
    check("rst_sw_start", sw_start, 0);
    check("rst_sw_sel",   sw_sel,   3);
    check("rst_sw_clear", sw_clear, 0);
    check("rst_running",  running,  0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data",  tx_data,  0);
    check("rst_busy",     busy,     0);
    check("rst_overrun",  overrun,  0);

    // Toggle from the start button.
    step(8);
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    check("t1_sw_start", sw_start, 1);
    check("t1_sw_sel",   sw_sel,   0);
    check("t1_running",  running,  1);
    step(1);
    check("t1_sw_start_off", sw_start, 0);
    check("t1_sw_sel_off",   sw_sel,   3);
    check("t1_running_hold", running,  1);
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    check("t1_second_running", running, 0);
    step(1);

    // Same-cycle merging and priority.
    btn_start = 1'b1; send_rx(8'h53); btn_start = 1'b0;
    check("t2_merge_start",   sw_start, 1);
    check("t2_merge_running", running,  1);
    step(1);
    check("t2_merge_single",  sw_start, 0);
    btn_start = 1'b1; send_rx(8'h52); btn_start = 1'b0;
    check("t2_clr_sw_clear", sw_clear, 1);
    check("t2_clr_sw_start", sw_start, 0);
    check("t2_clr_running",  running,  0);
    step(1);
    check("t2_clr_off", sw_clear, 0);
    send_rx(8'h73);
    check("t2_lower_s", running, 1);
    send_rx(8'h72);
    check("t2_lower_r_clear",   sw_clear, 1);
    check("t2_lower_r_running", running,  0);
    send_rx(8'h58);
    check("t2_ignored_start",   sw_start, 0);
    check("t2_ignored_running", running,  0);

    // Lower-case report, then lap-button report at the top of the range.
    push_report(0, 0, 0, 0);
    send_rx(8'h74);
    wait_idle();
    set_time(23, 59, 59, 99);
    push_report(23, 59, 59, 99);
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
    check("lap_busy", busy, 1);
    wait_idle();

    // Streaming with tx_ready held high: consecutive bytes, 13-cycle report.
    set_time(1, 2, 3, 45);
    t3 = '{8'h30, 8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33,
           8'h2E, 8'h34, 8'h35, 8'h0D, 8'h0A};
    foreach (t3[i]) exp_q.push_back(t3[i]);
    send_rx(8'h54);
    step(12);
    check("t3_busy_last", busy, 1);
    step(1);
    check("t3_busy_done", busy, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Backpressure toggling every cycle; inputs change mid-transfer.
    set_time(12, 34, 56, 78);
    push_report(12, 34, 56, 78);
    send_rx(8'h54);
    for (int i = 0; i < 40 && busy; i++) begin
      tx_ready = ~tx_ready;
      if (i == 4) set_time(9, 8, 7, 6);
      step(1);
    end
    check("t4_done", busy, 0);
    tx_ready = 1'b1;
    check("t4_queue_empty", exp_q.size(), 0);

    // Pending request, fresh snapshot, overrun and its clear.
    set_time(1, 0, 0, 0);
    push_report(1, 0, 0, 0);
    send_rx(8'h4C);
    push_report(2, 0, 0, 0);
    send_rx(8'h4C);
    check("t5_no_overrun_yet", overrun, 0);
    set_time(2, 0, 0, 0);
    send_rx(8'h4C);
    check("t5_overrun_set", overrun, 1);
    step(11);
    check("t5_gap_idle", busy, 0);
    step(1);
    check("t5_pending_start", busy, 1);
    wait_idle();
    check("t5_overrun_sticky", overrun, 1);
    send_rx(8'h52);
    check("t5_overrun_cleared", overrun, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Reset during byte 5 abandons the report.
    send_rx(8'h53);
    check("t6_running", running, 1);
    set_time(1, 2, 3, 45);
    push_report(1, 2, 3, 45);
    send_rx(8'h54);
    step(5);
    tx_ready = 1'b0;
    check("t6_byte5_valid", tx_valid, 1);
    check("t6_byte5_data",  tx_data,  8'h3A);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tx_valid", tx_valid, 0);
    check("t6_rst_busy",     busy,     0);
    check("t6_rst_running",  running,  0);
    check("t6_rst_tx_data",  tx_data,  0);
    check("t6_bytes_left",   exp_q.size(), 8);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    tx_ready = 1'b1;
    step(1);
    push_report(1, 2, 3, 45);
    send_rx(8'h54);
    check("t6_restart_byte0", tx_data, 8'h30);
    wait_idle();
    step(3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
